elevator_scheduler: RTL and testbench

Request scheduler and motion sequencer for the 4-storey elevator. It latches car and hall calls, picks travel direction with a collective (SCAN) policy, and steps the car floor-by-floor. At each serviced floor it starts the door-open timer via `StOpen` and waits for that timer's `endOpen` before deciding the next move. It sits between the button/debounce logic and the door timer, and its outputs feed the floor display.

---
 rtl/elevator_scheduler_if.sv | 25 ++
 rtl/elevator_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_scheduler_if.sv
// Call inputs, door-timer handshake and status outputs shared by the
// elevator scheduler and whatever drives or observes it.
interface elevator_scheduler_if;
    logic [3:0] car_call;
    logic [3:0] up_call;
    logic [3:0] down_call;
    logic       endOpen;
    logic       StOpen;
    logic [1:0] floor;
    logic [1:0] dir;
    logic       moving;
    logic [3:0] car_pend;
    logic [3:0] up_pend;
    logic [3:0] down_pend;

    modport master (
        output car_call, up_call, down_call, endOpen,
        input  StOpen, floor, dir, moving, car_pend, up_pend, down_pend
    );

    modport slave (
        input  car_call, up_call, down_call, endOpen,
        output StOpen, floor, dir, moving, car_pend, up_pend, down_pend
    );
endinterface

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) request scheduler and floor-by-floor motion sequencer
// for a 4-storey car; hands each stop to the external door-open timer.
module elevator_scheduler #(
    parameter int MOVE_TICKS = 8
) (
    input  logic                 CP,
    input  logic                 rst,
    elevator_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_CHECK, S_DOOR, S_DECIDE} state_t;
    typedef enum logic [1:0] {DIR_IDLE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10} dir_t;

    localparam logic [6:0] LAST_TICK = 7'(MOVE_TICKS - 1);

    state_t     r_state;
    dir_t       r_dir;
    logic [1:0] r_floor;
    logic [6:0] r_cnt;
    logic       r_stopen;
    logic       r_moving;
    logic [3:0] r_car;
    logic [3:0] r_up;
    logic [3:0] r_dn;

    logic [3:0] w_all;
    logic [3:0] w_here_oh;
    logic       w_above;
    logic       w_below;
    logic       w_here;
    logic       w_beyond;
    logic       w_behind;
    logic       w_stop;
    logic       w_dec_move;
    dir_t       w_dec_dir;
    logic [3:0] w_clr_car;
    logic [3:0] w_clr_up;
    logic [3:0] w_clr_dn;
    logic       w_cleared;
    logic [3:0] w_call_mask;

    assign w_all     = r_car | r_up | r_dn;
    assign w_here_oh = 4'b0001 << r_floor;
    assign w_above   = |(w_all & (4'b1110 << r_floor));
    assign w_below   = |(w_all & ~(4'b1111 << r_floor));
    assign w_here    = |(w_all & w_here_oh);

    // Door already open: calls for the current floor are dropped rather than latched.
    assign w_call_mask = (r_state == S_DOOR) ? ~w_here_oh : '1;

    always_comb begin
        w_beyond   = 1'b0;
        w_behind   = 1'b0;
        w_dec_move = 1'b0;
        w_dec_dir  = r_dir;
        case (r_dir)
            DIR_UP:  begin w_beyond = w_above; w_behind = w_below; end
            DIR_DN:  begin w_beyond = w_below; w_behind = w_above; end
            default: begin w_beyond = 1'b0;    w_behind = 1'b0;    end
        endcase

        // With no travel direction the choice degenerates to up-first.
        if (w_beyond) begin
            w_dec_move = 1'b1;
        end else if (w_behind) begin
            w_dec_move = 1'b1;
            w_dec_dir  = (r_dir == DIR_UP) ? DIR_DN : DIR_UP;
        end else if (r_dir == DIR_IDLE && w_above) begin
            w_dec_move = 1'b1;
            w_dec_dir  = DIR_UP;
        end else if (r_dir == DIR_IDLE && w_below) begin
            w_dec_move = 1'b1;
            w_dec_dir  = DIR_DN;
        end

        w_stop = r_car[r_floor]
               | ((r_dir == DIR_UP) & r_up[r_floor])
               | ((r_dir == DIR_DN) & r_dn[r_floor])
               | ~w_beyond;

        w_clr_car = '0;
        w_clr_up  = '0;
        w_clr_dn  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_clr_car = w_here_oh;
                    w_clr_up  = w_here_oh;
                    w_clr_dn  = w_here_oh;
                end
            end
            S_CHECK: begin
                if (w_stop) begin
                    w_clr_car = w_here_oh;
                    if (r_dir == DIR_UP || !w_beyond) w_clr_up = w_here_oh;
                    if (r_dir == DIR_DN || !w_beyond) w_clr_dn = w_here_oh;
                end
            end
            S_DECIDE: begin
                if (!w_dec_move && w_here) begin
                    w_clr_car = w_here_oh;
                    w_clr_up  = w_here_oh;
                    w_clr_dn  = w_here_oh;
                end
            end
            default: ;
        endcase

        w_cleared = |((w_clr_car & r_car) | (w_clr_up & r_up) | (w_clr_dn & r_dn));
    end

    always_ff @(posedge CP) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dir    <= DIR_IDLE;
            r_floor  <= '0;
            r_cnt    <= '0;
            r_stopen <= 1'b0;
            r_moving <= 1'b0;
            r_car    <= '0;
            r_up     <= '0;
            r_dn     <= '0;
        end else begin
            // A clear only loses to a same-cycle call outside DOOR, via the OR after masking.
            r_car <= (r_car & ~w_clr_car) | (bus.car_call & w_call_mask);
            r_up  <= ((r_up & ~w_clr_up) | (bus.up_call & w_call_mask)) & 4'b0111;
            r_dn  <= ((r_dn & ~w_clr_dn) | (bus.down_call & w_call_mask)) & 4'b1110;

            case (r_state)
                S_IDLE: begin
                    if (w_here) begin
                        r_state  <= S_DOOR;
                        r_stopen <= 1'b1;
                    end else if (w_dec_move) begin
                        r_state  <= S_MOVE;
                        r_dir    <= w_dec_dir;
                        r_moving <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_MOVE: begin
                    if (r_cnt == LAST_TICK) begin
                        r_cnt    <= '0;
                        r_state  <= S_CHECK;
                        r_moving <= 1'b0;
                        if (r_dir == DIR_UP)      r_floor <= r_floor + 2'd1;
                        else if (r_dir == DIR_DN) r_floor <= r_floor - 2'd1;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_CHECK: begin
                    if (!w_stop) begin
                        r_state  <= S_MOVE;
                        r_moving <= 1'b1;
                    end else if (w_cleared) begin
                        r_state  <= S_DOOR;
                        r_stopen <= 1'b1;
                    end else begin
                        r_state <= S_DECIDE;
                    end
                end
                S_DOOR: begin
                    if (bus.endOpen) begin
                        r_state  <= S_DECIDE;
                        r_stopen <= 1'b0;
                    end
                end
                S_DECIDE: begin
                    if (w_dec_move) begin
                        r_state  <= S_MOVE;
                        r_dir    <= w_dec_dir;
                        r_moving <= 1'b1;
                        r_cnt    <= '0;
                    end else if (w_here) begin
                        r_state  <= S_DOOR;
                        r_stopen <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_dir   <= DIR_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.StOpen    = r_stopen;
    assign bus.floor     = r_floor;
    assign bus.dir       = r_dir;
    assign bus.moving    = r_moving;
    assign bus.car_pend  = r_car;
    assign bus.up_pend   = r_up;
    assign bus.down_pend = r_dn;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: a trip-level SCAN model predicts the floors where the door
// opens; a monitor pops and compares on every StOpen rising edge.
module tb_elevator_scheduler;

    logic CP = 1'b0;
    logic rst;
    logic auto_mode;
    logic auto_eo;
    logic man_eo;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   m_floor = 0;

    elevator_scheduler_if bus();

    assign bus.endOpen = auto_mode ? auto_eo : man_eo;

    elevator_scheduler #(.MOVE_TICKS(4)) dut (
        .CP  (CP),
        .rst (rst),
        .bus (bus)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Trip-level SCAN: sweep to the furthest pending floor, stopping at car
    // calls and same-direction hall calls, then reverse.
    task automatic model_push(input logic [3:0] c, input logic [3:0] u, input logic [3:0] d);
        logic [3:0] car, up, dn, all;
        int f, dir, ext, g;
        car = c;
        up  = u & 4'b0111;
        dn  = d & 4'b1110;
        f   = m_floor;
        dir = 0;
        for (int it = 0; it < 8; it++) begin
            all = car | up | dn;
            if (all == 4'b0000) break;
            if (dir == 0 && all[f]) begin
                exp_q.push_back(f);
                car[f] = 1'b0; up[f] = 1'b0; dn[f] = 1'b0;
            end else begin
                if (dir == 0) dir = ((all >> (f + 1)) != 4'b0000) ? 1 : -1;
                ext = f;
                if (dir == 1) begin
                    for (int i = 0; i < 4; i++) if (all[i]) ext = i;
                end else begin
                    for (int i = 3; i >= 0; i--) if (all[i]) ext = i;
                end
                g = f;
                while (g != ext) begin
                    g = g + dir;
                    if (car[g] || (dir == 1 ? up[g] : dn[g]) || g == ext) begin
                        exp_q.push_back(g);
                        car[g] = 1'b0;
                        if (dir == 1) up[g] = 1'b0; else dn[g] = 1'b0;
                        if (g == ext) begin up[g] = 1'b0; dn[g] = 1'b0; end
                    end
                end
                f   = ext;
                dir = -dir;
            end
        end
        m_floor = f;
    endtask

    task automatic wait_idle(input string name);
        int stable = 0;
        int cyc = 0;
        while (stable < 2 && cyc < 3000) begin
            @(negedge CP);
            cyc++;
            if (!bus.StOpen && !bus.moving && bus.dir == 2'b00 &&
                bus.car_pend == 4'b0 && bus.up_pend == 4'b0 && bus.down_pend == 4'b0)
                stable++;
            else
                stable = 0;
        end
        if (stable < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: got busy after %0d cycles required idle", name, cyc);
        end
    endtask

    task automatic run_scenario(input logic [3:0] c, input logic [3:0] u, input logic [3:0] d,
                                input string name);
        wait_idle({name, "_pre"});
        model_push(c, u, d);
        @(negedge CP);
        bus.car_call = c; bus.up_call = u; bus.down_call = d;
        @(negedge CP);
        bus.car_call = '0; bus.up_call = '0; bus.down_call = '0;
        wait_idle(name);
        check({name, "_floor"}, 32'(bus.floor), 32'(m_floor));
        check({name, "_doors_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor plus travel-bound check.
    initial begin
        logic prev;
        int   e;
        prev = 1'b0;
        forever begin
            @(negedge CP);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.StOpen && !prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL door_unexpected: got door at floor %0d required none", bus.floor);
                    end else begin
                        e = exp_q.pop_front();
                        check("door_floor", 32'(bus.floor), 32'(e));
                    end
                end
                check("bound", 32'((bus.moving && bus.dir == 2'b01 && bus.floor == 2'd3) ||
                                   (bus.moving && bus.dir == 2'b10 && bus.floor == 2'd0) ||
                                   bus.dir == 2'b11), 32'd0);
                prev = bus.StOpen;
            end
        end
    end

    // Door-timer responder with random latency; random endOpen noise while moving.
    initial begin
        int wcnt;
        wcnt    = 0;
        auto_eo = 1'b0;
        forever begin
            @(negedge CP);
            if (bus.StOpen) begin
                if (wcnt == 0) auto_eo = 1'b1;
                else begin auto_eo = 1'b0; wcnt--; end
            end else begin
                wcnt    = $urandom_range(0, 3);
                auto_eo = bus.moving && ($urandom_range(0, 7) == 0);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        int k, guard;
        rst = 1'b1; auto_mode = 1'b0; man_eo = 1'b0;
        bus.car_call = '0; bus.up_call = '0; bus.down_call = '0;
        repeat (2) @(posedge CP);
        #1;
        check("rst_floor",  32'(bus.floor),     32'd0);
        check("rst_dir",    32'(bus.dir),       32'd0);
        check("rst_stopen", 32'(bus.StOpen),    32'd0);
        check("rst_moving", 32'(bus.moving),    32'd0);
        check("rst_car",    32'(bus.car_pend),  32'd0);
        check("rst_up",     32'(bus.up_pend),   32'd0);
        check("rst_down",   32'(bus.down_pend), 32'd0);
        @(negedge CP); rst = 1'b0;

        // Floor 0 -> 2 timing with MOVE_TICKS=4.
        exp_q.push_back(2);
        @(negedge CP); bus.car_call = 4'b0100;
        @(posedge CP); #1;
        check("tim_latched", 32'(bus.car_pend), 32'h4);
        check("tim_moving0", 32'(bus.moving), 32'd0);
        @(negedge CP); bus.car_call = '0;
        for (k = 1; k <= 11; k++) begin
            @(posedge CP); #1;
            check("tim_moving", 32'(bus.moving), 32'((k >= 1 && k <= 4) || (k >= 6 && k <= 9)));
            check("tim_floor",  32'(bus.floor),  (k < 5) ? 32'd0 : (k < 10) ? 32'd1 : 32'd2);
            check("tim_stopen", 32'(bus.StOpen), 32'(k >= 11));
        end
        @(negedge CP); bus.car_call = 4'b0100;
        @(posedge CP); #1;
        check("door_call_masked", 32'(bus.car_pend), 32'd0);
        @(negedge CP); bus.car_call = '0; man_eo = 1'b1;
        @(posedge CP); #1;
        check("door_close", 32'(bus.StOpen), 32'd0);
        @(negedge CP); man_eo = 1'b0;
        @(posedge CP); #1;
        check("post_door_dir",    32'(bus.dir),    32'd0);
        check("post_door_moving", 32'(bus.moving), 32'd0);
        m_floor = 2;

        // endOpen during MOVE has no effect.
        exp_q.push_back(0);
        @(negedge CP); bus.car_call = 4'b0001;
        @(negedge CP); bus.car_call = '0;
        @(negedge CP); man_eo = 1'b1;
        @(posedge CP); #1;
        check("eo_move_moving", 32'(bus.moving), 32'd1);
        check("eo_move_stopen", 32'(bus.StOpen), 32'd0);
        @(negedge CP); man_eo = 1'b0; auto_mode = 1'b1;
        wait_idle("eo_move");
        check("eo_move_floor", 32'(bus.floor), 32'd0);
        m_floor = 0;

        // Hall call at the current floor: door with no motion.
        auto_mode = 1'b0;
        exp_q.push_back(0);
        @(negedge CP); bus.up_call = 4'b0001;
        @(posedge CP); #1;
        check("here_latched", 32'(bus.up_pend), 32'h1);
        @(negedge CP); bus.up_call = '0;
        @(posedge CP); #1;
        check("here_stopen", 32'(bus.StOpen),  32'd1);
        check("here_moving", 32'(bus.moving),  32'd0);
        check("here_floor",  32'(bus.floor),   32'd0);
        check("here_clear",  32'(bus.up_pend), 32'd0);
        auto_mode = 1'b1;

        run_scenario(4'b1000, 4'b0100, 4'b0010, "mixed");
        run_scenario(4'b1001, 4'b0000, 4'b0000, "ends");
        for (int n = 0; n < 40; n++)
            run_scenario(4'($urandom), 4'($urandom), 4'($urandom), "rand");

        // Reset while the door is open.
        wait_idle("rst_door_pre");
        auto_mode = 1'b0;
        exp_q.push_back(m_floor);
        oh = 4'b0001 << m_floor;
        @(negedge CP); bus.car_call = oh;
        @(negedge CP); bus.car_call = '0;
        guard = 0;
        while (!bus.StOpen && guard < 20) begin @(negedge CP); guard++; end
        check("rst_door_reached", 32'(bus.StOpen), 32'd1);
        rst = 1'b1;
        @(posedge CP); #1;
        check("rst_door_stopen", 32'(bus.StOpen), 32'd0);
        check("rst_door_floor",  32'(bus.floor),  32'd0);
        check("rst_door_dir",    32'(bus.dir),    32'd0);
        check("rst_door_pend",   32'(bus.car_pend | bus.up_pend | bus.down_pend), 32'd0);
        @(negedge CP); rst = 1'b0;
        repeat (2) @(negedge CP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
